calc_sequencer: RTL and testbench

//   Clocked controller for the calculator datapath. Synchronises the two push buttons.

---
 rtl/calc_pkg.sv | 36 +++
 rtl/calc_if.sv | 32 +++
 rtl/btn_edge.sv | 26 ++
 rtl/calc_sequencer.sv | 126 ++++++++++++
 tb/tb_calc_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared calculator constants: sequencer states, display codes, ALU opcodes.
// Used by the sequencer, the ALU and the display mux.
package calc_pkg;

  typedef enum logic [2:0] {
    S_WAIT        = 3'd0,
    S_LOAD_FIRST  = 3'd1,
    S_LOAD_SECOND = 3'd2,
    S_ISSUE       = 3'd3,
    S_BUSY        = 3'd4,
    S_DONE        = 3'd5
  } state_t;

  localparam logic [1:0] DISP_WAIT = 2'b00;
  localparam logic [1:0] DISP_LDA  = 2'b01;
  localparam logic [1:0] DISP_LDB  = 2'b10;
  localparam logic [1:0] DISP_RUN  = 2'b11;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  function automatic logic [1:0] disp_of(input state_t s);
    logic [1:0] d;
    d = DISP_RUN;
    case (s)
      S_WAIT:        d = DISP_WAIT;
      S_LOAD_FIRST:  d = DISP_LDA;
      S_LOAD_SECOND: d = DISP_LDB;
      default:       d = DISP_RUN;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/calc_if.sv
// Sequencer bundle: buttons, switches and ALU handshake in,
// registered operands, result and status out.
interface calc_if #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 16
);
  logic              btnr;
  logic              btnl;
  logic [DATA_W+1:0] sw;
  logic              alu_done;
  logic [RES_W-1:0]  alu_result;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic [1:0]        op;
  logic              alu_start;
  logic [RES_W-1:0]  result;
  logic              error;
  logic              busy;
  logic [1:0]        disp_state;

  modport master (
    output btnr, btnl, sw, alu_done, alu_result,
    input  operand_a, operand_b, op, alu_start,
    input  result, error, busy, disp_state
  );

  modport slave (
    input  btnr, btnl, sw, alu_done, alu_result,
    output operand_a, operand_b, op, alu_start,
    output result, error, busy, disp_state
  );
endinterface

// File: rtl/btn_edge.sv
// Button front end: 2-FF synchroniser followed by a rising-edge detect.
// One clk-wide pulse per press, however long the button is held.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);
  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= btn;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign pulse = r_s2 & ~r_s3;
endmodule

// File: rtl/calc_sequencer.sv
// Calculator controller: operand entry, one ALU start pulse,
// done/timeout wait, held result and error for the display.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int RES_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic  clk,
  input  logic  reset,
  calc_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT);

  logic w_r_ev;
  logic w_l_ev;

  state_t            r_state, w_state_nx;
  logic [DATA_W-1:0] r_a, w_a_nx;
  logic [DATA_W-1:0] r_b, w_b_nx;
  logic [1:0]        r_op, w_op_nx;
  logic [RES_W-1:0]  r_res, w_res_nx;
  logic              r_err, w_err_nx;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nx;

  btn_edge u_btnr (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.btnr),
    .pulse (w_r_ev)
  );

  btn_edge u_btnl (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.btnl),
    .pulse (w_l_ev)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_WAIT;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_a     <= w_a_nx;
      r_b     <= w_b_nx;
      r_op    <= w_op_nx;
      r_res   <= w_res_nx;
      r_err   <= w_err_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_a_nx     = r_a;
    w_b_nx     = r_b;
    w_op_nx    = r_op;
    w_res_nx   = r_res;
    w_err_nx   = r_err;
    w_cnt_nx   = r_cnt;
    // Clear beats every other event, including a coincident done/timeout.
    if (w_l_ev) begin
      w_state_nx = S_WAIT;
      w_a_nx     = '0;
      w_b_nx     = '0;
      w_op_nx    = '0;
      w_res_nx   = '0;
      w_err_nx   = 1'b0;
      w_cnt_nx   = '0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (w_r_ev) w_state_nx = S_LOAD_FIRST;
        end
        S_LOAD_FIRST: begin
          w_a_nx = bus.sw[DATA_W-1:0];
          if (w_r_ev) w_state_nx = S_LOAD_SECOND;
        end
        S_LOAD_SECOND: begin
          w_b_nx = bus.sw[DATA_W-1:0];
          if (w_r_ev) begin
            w_op_nx    = bus.sw[DATA_W+1:DATA_W];
            w_state_nx = S_ISSUE;
          end
        end
        S_ISSUE: begin
          w_cnt_nx   = '0;
          w_state_nx = S_BUSY;
        end
        S_BUSY: begin
          w_cnt_nx = r_cnt + 1'b1;
          if (bus.alu_done) begin
            w_res_nx   = bus.alu_result;
            w_err_nx   = 1'b0;
            w_state_nx = S_DONE;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            w_res_nx   = '0;
            w_err_nx   = 1'b1;
            w_state_nx = S_DONE;
          end
        end
        S_DONE: begin
          if (w_r_ev) w_state_nx = S_LOAD_FIRST;
        end
        default: w_state_nx = S_WAIT;
      endcase
    end
  end

  assign bus.operand_a  = r_a;
  assign bus.operand_b  = r_b;
  assign bus.op         = r_op;
  assign bus.result     = r_res;
  assign bus.error      = r_err;
  assign bus.alu_start  = (r_state == S_ISSUE);
  assign bus.busy       = (r_state == S_ISSUE) | (r_state == S_BUSY);
  assign bus.disp_state = disp_of(r_state);
endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: entry, done, timeout,
// abort, button corner cases and async reset, with a result scoreboard.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int DATA_W  = 8;
  localparam int RES_W   = 16;
  localparam int TIMEOUT = 64;

  typedef struct {
    logic [RES_W-1:0] res;
    logic             err;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_start = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  calc_if #(.DATA_W(DATA_W), .RES_W(RES_W)) bus ();

  calc_sequencer #(
    .DATA_W  (DATA_W),
    .RES_W   (RES_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always @(posedge clk) if (bus.alu_start === 1'b1) n_start++;

  task automatic press_r();
    bus.btnr = 1'b1;
    repeat (3) @(negedge clk);
    bus.btnr = 1'b0;
  endtask

  task automatic enter(input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] o);
    bus.sw = {2'b00, a};
    press_r();
    repeat (2) @(negedge clk);
    press_r();
    repeat (2) @(negedge clk);
    bus.sw = {o, b};
    press_r();
  endtask

  task automatic test_reset();
    logic [38:0] v;
    bus.btnr = 0; bus.btnl = 0; bus.sw = '0;
    bus.alu_done = 0; bus.alu_result = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    v = {bus.operand_a, bus.operand_b, bus.op, bus.result,
         bus.error, bus.alu_start, bus.busy, bus.disp_state};
    n_cmp++;
    if (v !== '0) begin
      n_bad++; $display("FAIL reset_outs: got %h want 0", v);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.disp_state !== DISP_WAIT) begin
      n_bad++; $display("FAIL reset_disp: got %b want 00", bus.disp_state);
    end
  endtask

  task automatic test_add();
    int   s0;
    int   k;
    exp_t e;
    s0 = n_start;
    enter(8'h05, 8'h0C, OP_ADD);
    n_cmp++;
    if (bus.alu_start !== 1'b1) begin
      n_bad++; $display("FAIL add_start_hi: got %b want 1", bus.alu_start);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.alu_start !== 1'b0) begin
      n_bad++; $display("FAIL add_start_lo: got %b want 0", bus.alu_start);
    end
    repeat (3) @(negedge clk);
    bus.alu_done = 1'b1; bus.alu_result = 16'h0011;
    sb.push_back('{res: 16'h0011, err: 1'b0});
    @(negedge clk);
    bus.alu_done = 1'b0; bus.alu_result = '0;
    k = 0;
    while (bus.busy && k < 20) begin @(negedge clk); k++; end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL add_done_wait: busy %b want 0", bus.busy);
    end
    n_cmp++;
    if (bus.disp_state !== DISP_RUN) begin
      n_bad++; $display("FAIL add_disp: got %b want 11", bus.disp_state);
    end
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++; $display("FAIL add_sb: got empty want entry");
    end else begin
      e = sb.pop_front();
      if ({bus.result, bus.error} !== {e.res, e.err}) begin
        n_bad++;
        $display("FAIL add_result: got %h/%b want %h/%b",
                 bus.result, bus.error, e.res, e.err);
      end
    end
    n_cmp++;
    if (n_start - s0 !== 1) begin
      n_bad++; $display("FAIL add_start_cnt: got %0d want 1", n_start - s0);
    end
    n_cmp++;
    if ({bus.operand_a, bus.operand_b, bus.op} !== {8'h05, 8'h0C, OP_ADD}) begin
      n_bad++;
      $display("FAIL add_operands: got %h %h %b want 05 0c 00",
               bus.operand_a, bus.operand_b, bus.op);
    end
  endtask

  task automatic test_timeout();
    int   k;
    exp_t e;
    bus.sw = {2'b00, 8'h05};
    press_r();
    n_cmp++;
    if ({bus.disp_state, bus.result} !== {DISP_LDA, 16'h0011}) begin
      n_bad++;
      $display("FAIL done_keep: got %b/%h want 01/0011",
               bus.disp_state, bus.result);
    end
    repeat (2) @(negedge clk);
    press_r();
    repeat (2) @(negedge clk);
    bus.sw = {OP_MUL, 8'h0C};
    press_r();
    sb.push_back('{res: '0, err: 1'b1});
    k = 0;
    while (bus.busy && k < TIMEOUT + 10) begin @(negedge clk); k++; end
    n_cmp++;
    if (k != TIMEOUT + 1) begin
      n_bad++; $display("FAIL to_cycles: got %0d want %0d", k, TIMEOUT + 1);
    end
    n_cmp++;
    if (bus.op !== OP_MUL) begin
      n_bad++; $display("FAIL to_op: got %b want 10", bus.op);
    end
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++; $display("FAIL to_sb: got empty want entry");
    end else begin
      e = sb.pop_front();
      if ({bus.result, bus.error} !== {e.res, e.err}) begin
        n_bad++;
        $display("FAIL to_result: got %h/%b want %h/%b",
                 bus.result, bus.error, e.res, e.err);
      end
    end
  endtask

  task automatic test_abort();
    enter(8'h21, 8'h03, OP_SUB);
    repeat (3) @(negedge clk);
    bus.btnl = 1'b1;
    repeat (3) @(negedge clk);
    bus.btnl = 1'b0;
    n_cmp++;
    if (bus.disp_state !== DISP_WAIT) begin
      n_bad++; $display("FAIL abort_disp: got %b want 00", bus.disp_state);
    end
    n_cmp++;
    if ({bus.operand_a, bus.op, bus.result, bus.error} !== '0) begin
      n_bad++;
      $display("FAIL abort_clear: got a=%h op=%b r=%h e=%b want 0",
               bus.operand_a, bus.op, bus.result, bus.error);
    end
    repeat (2) @(negedge clk);
    bus.alu_done = 1'b1; bus.alu_result = 16'h00FF;
    @(negedge clk);
    bus.alu_done = 1'b0; bus.alu_result = '0;
    @(negedge clk);
    n_cmp++;
    if ({bus.disp_state, bus.result, bus.error} !== {DISP_WAIT, 16'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL abort_late_done: got %b/%h/%b want 00/0000/0",
               bus.disp_state, bus.result, bus.error);
    end
  endtask

  task automatic test_done_in_wait();
    bus.alu_done = 1'b1; bus.alu_result = 16'h0042;
    @(negedge clk);
    bus.alu_done = 1'b0; bus.alu_result = '0;
    @(negedge clk);
    n_cmp++;
    if ({bus.disp_state, bus.result} !== {DISP_WAIT, 16'h0}) begin
      n_bad++;
      $display("FAIL wait_done: got %b/%h want 00/0000",
               bus.disp_state, bus.result);
    end
  endtask

  task automatic test_held();
    bus.btnr = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.disp_state !== DISP_WAIT) begin
      n_bad++; $display("FAIL held_lat1: got %b want 00", bus.disp_state);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.disp_state !== DISP_WAIT) begin
      n_bad++; $display("FAIL held_lat2: got %b want 00", bus.disp_state);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.disp_state !== DISP_LDA) begin
      n_bad++; $display("FAIL held_lat3: got %b want 01", bus.disp_state);
    end
    repeat (97) @(negedge clk);
    bus.btnr = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.disp_state !== DISP_LDA) begin
      n_bad++; $display("FAIL held_once: got %b want 01", bus.disp_state);
    end
    bus.btnl = 1'b1;
    repeat (3) @(negedge clk);
    bus.btnl = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.disp_state !== DISP_WAIT) begin
      n_bad++; $display("FAIL held_clear: got %b want 00", bus.disp_state);
    end
  endtask

  task automatic test_simultaneous();
    int s0;
    bus.sw = {2'b00, 8'h09};
    press_r();
    repeat (2) @(negedge clk);
    press_r();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.disp_state !== DISP_LDB) begin
      n_bad++; $display("FAIL sim_pre: got %b want 10", bus.disp_state);
    end
    s0 = n_start;
    bus.btnr = 1'b1; bus.btnl = 1'b1;
    repeat (3) @(negedge clk);
    bus.btnr = 1'b0; bus.btnl = 1'b0;
    n_cmp++;
    if (bus.disp_state !== DISP_WAIT) begin
      n_bad++; $display("FAIL sim_wait: got %b want 00", bus.disp_state);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (n_start != s0 || bus.disp_state !== DISP_WAIT) begin
      n_bad++;
      $display("FAIL sim_nostart: got starts=%0d disp=%b want 0/00",
               n_start - s0, bus.disp_state);
    end
    n_cmp++;
    if (bus.operand_a !== 8'h00) begin
      n_bad++; $display("FAIL sim_opa: got %h want 00", bus.operand_a);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [38:0] v;
    enter(8'h7F, 8'h01, OP_DIV);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL rst_pre_busy: got %b want 1", bus.busy);
    end
    #2 reset = 1'b1;
    #1;
    v = {bus.operand_a, bus.operand_b, bus.op, bus.result,
         bus.error, bus.alu_start, bus.busy, bus.disp_state};
    n_cmp++;
    if (v !== '0) begin
      n_bad++; $display("FAIL rst_async: got %h want 0", v);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.disp_state, bus.busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_after: got %b/%b want 00/0",
               bus.disp_state, bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_timeout();
    test_abort();
    test_done_in_wait();
    test_held();
    test_simultaneous();
    test_reset_mid_busy();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL sb_empty: got %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
